// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl - stall/flush/forwarding controller for the 5-stage RV32I pipe.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-low reset
//   id_*                source registers/usage of the instruction in ID
//   ex_*                sources, destination, load flag and taken-branch of EX
//   mem_rd/regwrite     destination of the EX/MEM instruction (forwarding source)
//   mem_access          EX/MEM instruction is a load or store
//   dmem_ready          data memory completes the access this cycle
//   wb_rd/regwrite      destination of the MEM/WB instruction (forwarding source)
//   pc_en, *_en         pipeline register enables
//   ifid/idex_flush     load a bubble into the register (only when its enable is 1)
//   fwd_a/b_sel         EX operand source: 00 regfile, 01 EX/MEM, 10 MEM/WB
//   stall_cnt           cycles with pc_en low since reset (wrapping)
//   mem_err             sticky data-memory timeout flag
module pipe_hazard_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_load,
    input  logic             ex_branch_taken,
    input  logic [4:0]       mem_rd,
    input  logic             mem_regwrite,
    input  logic             mem_access,
    input  logic             dmem_ready,
    input  logic [4:0]       wb_rd,
    input  logic             wb_regwrite,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             mem_err
);

    typedef enum logic [1:0] {S_RUN, S_MEM_WAIT, S_ERROR} state_t;

    localparam int WC_W = $clog2(TIMEOUT + 1) + 1;

    state_t            r_state, w_next_state;
    logic [WC_W-1:0]   r_wait_cnt, w_next_wait;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic              r_mem_err, w_next_err;
    logic              w_load_use;
    logic              w_mem_stall;

    assign w_mem_stall = mem_access && !dmem_ready;
    assign w_load_use  = ex_load && (ex_rd != 5'd0) &&
                         ((id_rs1_used && id_rs1 == ex_rd) ||
                          (id_rs2_used && id_rs2 == ex_rd));

    always_comb begin
        w_next_state = r_state;
        w_next_wait  = r_wait_cnt;
        w_next_err   = r_mem_err;
        pc_en        = 1'b0;
        ifid_en      = 1'b0;
        ifid_flush   = 1'b0;
        idex_en      = 1'b0;
        idex_flush   = 1'b0;
        exmem_en     = 1'b0;
        memwb_en     = 1'b0;
        if (!rst) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_mem_stall) begin
                        // freeze everything; this cycle is the first waited cycle
                        w_next_state = S_MEM_WAIT;
                        w_next_wait  = WC_W'(1);
                    end else if (ex_branch_taken) begin
                        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (w_load_use) begin
                        // hold PC and IF/ID, insert one bubble into ID/EX
                        {idex_en, exmem_en, memwb_en} = 3'b111;
                        idex_flush = 1'b1;
                    end else begin
                        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
                    end
                end
                S_MEM_WAIT: begin
                    if (dmem_ready) begin
                        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
                        w_next_state = S_RUN;
                    end else if (r_wait_cnt >= WC_W'(TIMEOUT - 1)) begin
                        // this cycle is the TIMEOUT-th unanswered one
                        w_next_err   = 1'b1;
                        w_next_state = S_ERROR;
                    end else begin
                        w_next_wait = r_wait_cnt + WC_W'(1);
                    end
                end
                default: ;  // S_ERROR: frozen until reset
            endcase
        end
    end

    // Forwarding: EX/MEM wins over MEM/WB; x0 is never forwarded.
    always_comb begin
        fwd_a_sel = 2'b00;
        fwd_b_sel = 2'b00;
        if (rst) begin
            if (mem_regwrite && mem_rd != 5'd0 && mem_rd == ex_rs1)     fwd_a_sel = 2'b01;
            else if (wb_regwrite && wb_rd != 5'd0 && wb_rd == ex_rs1)   fwd_a_sel = 2'b10;
            if (mem_regwrite && mem_rd != 5'd0 && mem_rd == ex_rs2)     fwd_b_sel = 2'b01;
            else if (wb_regwrite && wb_rd != 5'd0 && wb_rd == ex_rs2)   fwd_b_sel = 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_RUN;
            r_wait_cnt  <= '0;
            r_stall_cnt <= '0;
            r_mem_err   <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_next_wait;
            r_mem_err  <= w_next_err;
            if (!pc_en) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign mem_err   = r_mem_err;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush/forwarding controller for the 5-stage RV32I pipeline. It drives the enable and flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC, and generates ALU operand forwarding selects. It also sequences multi-cycle data-memory accesses with a timeout watchdog, and counts stall cycles for performance monitoring.

Parameters:
TIMEOUT, 16, max cycles a data-memory access may wait for dmem_ready before error
CNT_W, 32, width of stall cycle counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-low
id_rs1  input  5  rs1 of instruction in ID
id_rs2  input  5  rs2 of instruction in ID
id_rs1_used  input  1  ID instruction reads rs1
id_rs2_used  input  1  ID instruction reads rs2
ex_rs1  input  5  rs1 of instruction in EX
ex_rs2  input  5  rs2 of instruction in EX
ex_rd  input  5  rd of instruction in EX
ex_load  input  1  EX instruction is a load
ex_branch_taken  input  1  branch/jump in EX redirects the PC
mem_rd  input  5  rd at EX/MEM output
mem_regwrite  input  1  EX/MEM instruction writes rd
mem_access  input  1  EX/MEM load_out OR store_out
dmem_ready  input  1  data memory completes access this cycle
wb_rd  input  5  rd at MEM/WB output
wb_regwrite  input  1  MEM/WB instruction writes rd
pc_en  output  1  PC update enable
ifid_en  output  1  IF/ID register enable
ifid_flush  output  1  IF/ID loads NOP bubble
idex_en  output  1  ID/EX register enable
idex_flush  output  1  ID/EX loads bubble
exmem_en  output  1  EX/MEM register enable
memwb_en  output  1  MEM/WB register enable
fwd_a_sel  output  2  EX operand A: 00 regfile, 01 EX/MEM alu_res, 10 MEM/WB result
fwd_b_sel  output  2  EX operand B, same encoding
stall_cnt  output  CNT_W  cycles with pc_en low since reset
mem_err  output  1  data-memory timeout occurred (sticky)

Behaviour:
- Single clock clk; rst synchronous, active-low. While rst=0 at a clock edge: state<=RUN, wait counter<=0, stall_cnt<=0, mem_err<=0. While rst is low, all *_en outputs=0, ifid_flush=idex_flush=1, fwd selects=00.
- States: RUN, MEM_WAIT, ERROR. Control outputs are combinational from state plus inputs.
- RUN, evaluated in priority order:
  1. mem_access && !dmem_ready: all enables 0, no flush; next MEM_WAIT, wait counter<=1.
  2. ex_branch_taken: all enables 1, ifid_flush=1, idex_flush=1 (two wrong-path instructions squashed, redirect taken same cycle).
  3. Load-use: ex_load && ex_rd!=0 && ((id_rs1_used && id_rs1==ex_rd) || (id_rs2_used && id_rs2==ex_rd)): pc_en=0, ifid_en=0, idex_en=1 with idex_flush=1, exmem_en=memwb_en=1. Exactly one bubble; recomputes clear next cycle.
  4. Otherwise all enables 1, flushes 0.
  - mem_access && dmem_ready in RUN completes with no stall.
- MEM_WAIT: all enables 0, flushes 0 (entire pipeline frozen, pending branch/load-use re-evaluated on exit). dmem_ready=1 -> all enables 1 this cycle, next RUN. Else wait counter increments; when counter reaches TIMEOUT with dmem_ready=0 -> mem_err<=1, next ERROR.
- ERROR: all enables 0, flushes 0; stays until rst=0.
- Forwarding (all states): fwd_a_sel=01 if mem_regwrite && mem_rd!=0 && mem_rd==ex_rs1; else 10 if wb_regwrite && wb_rd!=0 && wb_rd==ex_rs1; else 00. EX/MEM has priority over MEM/WB. fwd_b_sel identical with ex_rs2. x0 never forwarded.
- stall_cnt increments by 1 on every non-reset edge where pc_en=0; wraps at 2^CNT_W.
- Flush overrides enable only for the flushed register; enable=1 required for a flush to take effect.

Test Plan:
- Reset: hold rst=0 3 cycles with random inputs -> enables 0, flushes 1, stall_cnt=0, mem_err=0; release -> pc_en=1 first RUN cycle.
- Load-use: ex_load=1, ex_rd=5, id_rs1=5, id_rs1_used=1 -> one cycle pc_en=0, ifid_en=0, idex_flush=1; stall_cnt=1; next cycle with ex_load=0 -> all enables 1.
- Branch: ex_branch_taken=1 with simultaneous load-use condition -> ifid_flush=idex_flush=1, pc_en=1 (branch wins), stall_cnt unchanged.
- Memory wait: mem_access=1, dmem_ready=0 for 3 cycles then 1 -> all enables 0 for 3 cycles, 1 on the 4th, stall_cnt=3, state RUN.
- Timeout: TIMEOUT=4, mem_access=1, dmem_ready held 0 -> mem_err=1 after 4 wait cycles, enables remain 0 even after dmem_ready=1, until rst=0.
- Forwarding: ex_rs1=3, mem_rd=3/mem_regwrite=1, wb_rd=3/wb_regwrite=1 -> fwd_a_sel=01; mem_regwrite=0 -> 10; ex_rs2=0 with mem_rd=0 -> fwd_b_sel=00.
